// File: rtl/add12_sched.sv
// Round-robin sequencer sharing one 12-bit sign-magnitude adder; ack arrives 3 edges after grant (IDLE-LOAD-CALC-RESP).
// No backpressure on the result: requesters hold req until their one-cycle ack, later requests wait in IDLE.
module add12_sched #(
  parameter int N_REQ = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [13*N_REQ-1:0]  a_bus,
  input  logic [13*N_REQ-1:0]  b_bus,
  input  logic [N_REQ-1:0]     sub,
  output logic [N_REQ-1:0]     ack,
  output logic [12:0]          result,
  output logic                 ovf,
  output logic                 busy
);
  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, RESP} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] gnt, rr, pick;
  logic          found;
  int            idx;
  logic [12:0]   opa, opb, sum_res;
  logic          sum_ovf;
  logic [11:0]   ma, mb;
  logic [12:0]   mag_sum;

  // First requester at or after rr, wrapping modulo N_REQ
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int j = 0; j < N_REQ; j++) begin
      idx = int'(rr) + j;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  // Sign-magnitude add; equal magnitudes with opposite signs keep opA's sign
  always_comb begin
    ma      = opa[11:0];
    mb      = opb[11:0];
    mag_sum = {1'b0, ma} + {1'b0, mb};
    sum_res = '0;
    sum_ovf = 1'b0;
    if (opa[12] == opb[12]) begin
      sum_res = {opa[12], mag_sum[11:0]};
      sum_ovf = mag_sum[12];
    end else if (ma >= mb) begin
      sum_res = {opa[12], ma - mb};
    end else begin
      sum_res = {opb[12], mb - ma};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = LOAD;
      LOAD:    state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      rr     <= '0;
      gnt    <= '0;
      opa    <= '0;
      opb    <= '0;
      result <= '0;
      ovf    <= 1'b0;
      ack    <= '0;
    end else begin
      state <= state_nxt;
      ack   <= '0;
      case (state)
        IDLE: if (found) gnt <= pick;
        LOAD: begin
          opa <= a_bus[13*gnt +: 13];
          opb <= {b_bus[13*gnt + 12] ^ sub[gnt], b_bus[13*gnt +: 12]};
          rr  <= (gnt == IW'(N_REQ - 1)) ? '0 : gnt + 1'b1;
        end
        CALC: begin
          result   <= sum_res;
          ovf      <= sum_ovf;
          ack[gnt] <= 1'b1;   // registered so it is high for the whole RESP cycle
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
